oc_seq: RTL and testbench
=========================

# oc_seq

Output-compare sequencer: a bus-programmable queue of (compare value, OC config) entries that reprograms one `oc` channel automatically on each timer match. It sits between the CPU register bus and the `oc` channel's register port, turning single-shot compares into multi-edge waveform sequences without CPU intervention per edge.

## Interface
- `DEPTH`, 8: FIFO entries, power of two, 2..64
- `CW`, `$clog2(DEPTH)+1`: count width

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `addr_i`  in  32  CPU word address, sequencer registers 0..3
- `data_i`  in  32  CPU write data
- `wr_i`  in  1  CPU write strobe, one cycle
- `rd_i`  in  1  CPU read strobe, one cycle
- `data_o`  out  32  CPU read data, registered
- `tm1`, `tm2`  in  32  timer counts, same sources as the `oc` channel
- `oc_addr_o`  out  32  `oc` register address: 0 = OCCONF, 1 = OCR
- `oc_data_o`  out  32  `oc` write data
- `oc_wr_o`  out  1  `oc` write strobe

## Operation
- Registers:
  - 0 CTRL: bit0 EN, bit1 LOOP, bit2 FLUSH (write-1 pulse, reads 0)
  - 1 STAT, read-only except bit11: [CW-1:0] count, bit8 empty, bit9 full, bit10 busy (state≠IDLE), bit11 overrun (sticky, write 1 to clear)
  - 2 CMP: staging register for the compare value
  - 3 PUSH: write pushes {CMP, data_i} as one entry
- Entry: cmp[31:0], conf[31:0]. Timer select is conf bit3, same encoding as OCCONF: 0 = tm1, 1 = tm2.
- Push when full: entry dropped, overrun set.
- Push and pop in the same cycle while full: push accepted, count unchanged.
- FSM states:
  - IDLE: EN && !empty -> LOAD_OCR.
  - LOAD_OCR: `oc_wr_o`=1, addr 1, data = head.cmp -> LOAD_CONF.
  - LOAD_CONF: `oc_wr_o`=1, addr 0, data = head.conf -> WAIT.
  - WAIT: selected timer == head.cmp (exact equality) -> ADVANCE; EN=0 -> IDLE, head kept.
  - ADVANCE: pop head. With LOOP=1, the same entry is re-pushed at the tail in the same cycle. -> IDLE.
- EN cleared during LOAD_OCR/LOAD_CONF: the pair completes, then the FSM goes to IDLE from WAIT on the next cycle.
- FLUSH from any state: FIFO emptied, FSM -> IDLE next cycle, overrun cleared. A partially programmed `oc` is left as is.
- A push in the same cycle as FLUSH is discarded.
- A match value already passed waits for timer wrap-around. There is no timeout.

## Timing
- Reset: `data_o`=0, `oc_addr_o`=0, `oc_data_o`=0, `oc_wr_o`=0, CTRL=0, CMP=0, FIFO empty, overrun=0, state IDLE.
- Read: `data_o` is valid on the clock after `rd_i` and holds until the next read.
- Write: takes effect at the `wr_i` clock edge. A push raises count on the following cycle.
- Minimum latency, EN set to first `oc_wr_o`: 1 cycle (IDLE -> LOAD_OCR).
- Match to next entry's OCR write: 3 cycles (WAIT -> ADVANCE -> IDLE -> LOAD_OCR).
- `oc_wr_o` is high exactly 2 consecutive cycles per entry, never otherwise.

## Configuration
- `OC_SEQ_LOOP_EN` defined: LOOP bit implemented as above.
- `OC_SEQ_LOOP_EN` undefined: CTRL bit1 reads 0 and writes are ignored; ADVANCE always discards the head; no re-push logic is built.

## Structure
- Shared package `oc_pkg`: OC register addresses (OCCONF=0, OCR=1), OC mode enum, OC_TM_WRK bit index, sequencer register addresses, STAT bit positions, FSM state enum.
- Sub-module `oc_seq_fifo`: 64-bit-wide synchronous FIFO with push/pop/flush, count, full, empty. Simultaneous push+pop is legal at any fill level.

## Test plan
- Reset mid-WAIT with 3 entries queued -> all outputs 0, STAT reads 0x100 (empty), no `oc_wr_o`.
- Push {100,0x1}, {200,0x2}, set EN, ramp tm1 from 0 -> writes (1,100),(0,0x1); at tm1=100 writes (1,200),(0,0x2) exactly 3 cycles later; STAT goes empty after tm1=200.
- Push 9 entries with DEPTH=8 -> STAT count=8, full=1, overrun=1; write 0x800 to STAT -> overrun=0.
- LOOP=1, single entry {50,0x8}, drive tm2 ramp 0..63 repeatedly -> entry reloaded after every tm2=50 match; count stays 1 (with `OC_SEQ_LOOP_EN`).
- EN cleared in WAIT -> FSM IDLE, count unchanged. EN set again -> the same head is reloaded.
- FLUSH during LOAD_OCR -> no LOAD_CONF write, count=0, busy=0 next cycle.

Source files
------------

// File: rtl/oc_pkg.sv
// oc_pkg: shared definitions for the output-compare channel and its sequencer.
//   - oc register addresses (OCCONF, OCR), oc mode encoding, timer-select bit
//   - sequencer register map, CTRL/STAT bit positions, FSM state enum
//   - seq_entry_t: one queued {compare value, OCCONF value} pair
package oc_pkg;

  // oc channel register port
  localparam logic [31:0] OC_ADDR_OCCONF = 32'd0;
  localparam logic [31:0] OC_ADDR_OCR    = 32'd1;

  // OCCONF[2:0] mode field
  typedef enum logic [2:0] {
    OC_MODE_OFF       = 3'd0,
    OC_MODE_SET_HIGH  = 3'd1,
    OC_MODE_SET_LOW   = 3'd2,
    OC_MODE_TOGGLE    = 3'd3,
    OC_MODE_PULSE     = 3'd4,
    OC_MODE_PULSE_CNT = 3'd5,
    OC_MODE_PWM       = 3'd6,
    OC_MODE_PWM_FAULT = 3'd7
  } oc_mode_e;

  // OCCONF timer select: 0 = tm1, 1 = tm2
  localparam int unsigned OC_TM_WRK = 3;

  // Sequencer register map (CPU word addresses)
  localparam logic [31:0] SEQ_ADDR_CTRL = 32'd0;
  localparam logic [31:0] SEQ_ADDR_STAT = 32'd1;
  localparam logic [31:0] SEQ_ADDR_CMP  = 32'd2;
  localparam logic [31:0] SEQ_ADDR_PUSH = 32'd3;

  // CTRL bits
  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_LOOP  = 1;
  localparam int unsigned CTRL_FLUSH = 2;

  // STAT bits (count occupies [CW-1:0])
  localparam int unsigned STAT_EMPTY = 8;
  localparam int unsigned STAT_FULL  = 9;
  localparam int unsigned STAT_BUSY  = 10;
  localparam int unsigned STAT_OVR   = 11;

  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_LOAD_OCR  = 3'd1,
    SEQ_LOAD_CONF = 3'd2,
    SEQ_WAIT      = 3'd3,
    SEQ_ADVANCE   = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [31:0] cmp;
    logic [31:0] conf;
  } seq_entry_t;

endpackage

// File: rtl/oc_seq_fifo.sv
// oc_seq_fifo: synchronous FIFO holding sequencer entries.
//   clk, rst (async, active-high)
//   push_i/data_i : write one entry at the tail
//   pop_i         : drop the head
//   flush_i       : empty the FIFO (overrides push and pop)
//   head_o        : current head entry (combinational from storage)
//   count_o, full_o, empty_o : fill level
// Push and pop in the same cycle are legal at any fill level; when full,
// the pop frees the slot the push needs, so the push is accepted.
module oc_seq_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1,
  parameter int unsigned W     = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0) && !flush_i;
    do_push  = push_i && ((count_q != FULL_CNT) || do_pop) && !flush_i;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing reads a slot before it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/oc_seq.sv
// oc_seq: output-compare sequencer. Queues {compare, OCCONF} entries written
// over the CPU bus and reprograms one oc channel (OCR then OCCONF) each time
// the selected timer matches the head's compare value.
//   clk, rst (async, active-high)
//   addr_i/data_i/wr_i/rd_i/data_o : CPU register port (CTRL, STAT, CMP, PUSH)
//   tm1, tm2                        : timer counts, selected by conf bit3
//   oc_addr_o/oc_data_o/oc_wr_o     : write port into the oc channel
// Build option: define OC_SEQ_LOOP_EN to implement CTRL.LOOP (retired entries
// are re-queued at the tail); without it LOOP reads 0 and is never stored.
module oc_seq
  import oc_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        wr_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  input  logic [31:0] tm1,
  input  logic [31:0] tm2,
  output logic [31:0] oc_addr_o,
  output logic [31:0] oc_data_o,
  output logic        oc_wr_o
);

  seq_state_e    state_q, state_d;
  logic          en_q, en_d;
  logic [31:0]   cmp_q, cmp_d;
  logic          ovr_q, ovr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          oc_wr_q, oc_wr_d;
  logic [31:0]   oc_addr_q, oc_addr_d;
  logic [31:0]   oc_data_q, oc_data_d;

  logic          loop_en;
`ifdef OC_SEQ_LOOP_EN
  logic          loop_q, loop_d;
  assign loop_en = loop_q;
`else
  assign loop_en = 1'b0;
`endif

  logic          wr_ctrl, wr_stat, wr_cmp, wr_push;
  logic          flush, advance, repush, push_req, push_ok;
  logic          fifo_push;
  logic [63:0]   fifo_wdata, fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  seq_entry_t    head;
  logic [31:0]   sel_tm;
  logic [31:0]   stat_word, ctrl_word;

  assign head = seq_entry_t'(fifo_head);

  oc_seq_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .W     (64)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (advance),
    .flush_i (flush),
    .data_i  (fifo_wdata),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Bus decode and FIFO write arbitration
  always_comb begin
    wr_ctrl  = wr_i && (addr_i == SEQ_ADDR_CTRL);
    wr_stat  = wr_i && (addr_i == SEQ_ADDR_STAT);
    wr_cmp   = wr_i && (addr_i == SEQ_ADDR_CMP);
    wr_push  = wr_i && (addr_i == SEQ_ADDR_PUSH);
    flush    = wr_ctrl && data_i[CTRL_FLUSH];
    advance  = (state_q == SEQ_ADVANCE) && !flush;
    repush   = advance && loop_en;
    push_req = wr_push && !flush;
    // The single FIFO write port belongs to the loop re-push in ADVANCE;
    // a CPU push colliding with it is dropped and flagged as overrun.
    push_ok    = push_req && !repush && (!fifo_full || advance);
    fifo_push  = repush || push_ok;
    fifo_wdata = repush ? fifo_head : {cmp_q, data_i};
  end

  // Register file
  always_comb begin
    en_d  = wr_ctrl ? data_i[CTRL_EN] : en_q;
    cmp_d = wr_cmp ? data_i : cmp_q;
`ifdef OC_SEQ_LOOP_EN
    loop_d = wr_ctrl ? data_i[CTRL_LOOP] : loop_q;
`endif
    ovr_d = ovr_q;
    if (flush)                            ovr_d = 1'b0;
    else if (push_req && !push_ok)        ovr_d = 1'b1;
    else if (wr_stat && data_i[STAT_OVR]) ovr_d = 1'b0;

    ctrl_word            = '0;
    ctrl_word[CTRL_EN]   = en_q;
    ctrl_word[CTRL_LOOP] = loop_en;

    stat_word             = '0;
    stat_word[CW-1:0]     = fifo_count;
    stat_word[STAT_EMPTY] = fifo_empty;
    stat_word[STAT_FULL]  = fifo_full;
    stat_word[STAT_BUSY]  = (state_q != SEQ_IDLE);
    stat_word[STAT_OVR]   = ovr_q;

    rdata_d = rdata_q;
    if (rd_i) begin
      case (addr_i)
        SEQ_ADDR_CTRL: rdata_d = ctrl_word;
        SEQ_ADDR_STAT: rdata_d = stat_word;
        SEQ_ADDR_CMP:  rdata_d = cmp_q;
        default:       rdata_d = '0;
      endcase
    end
  end

  // Sequencer FSM; oc outputs are computed one state ahead so they are
  // registered yet aligned with LOAD_OCR/LOAD_CONF.
  always_comb begin
    sel_tm    = head.conf[OC_TM_WRK] ? tm2 : tm1;
    state_d   = state_q;
    oc_wr_d   = 1'b0;
    oc_addr_d = oc_addr_q;
    oc_data_d = oc_data_q;
    case (state_q)
      SEQ_IDLE: begin
        if (en_q && !fifo_empty) begin
          state_d   = SEQ_LOAD_OCR;
          oc_wr_d   = 1'b1;
          oc_addr_d = OC_ADDR_OCR;
          oc_data_d = head.cmp;
        end
      end
      SEQ_LOAD_OCR: begin
        state_d   = SEQ_LOAD_CONF;
        oc_wr_d   = 1'b1;
        oc_addr_d = OC_ADDR_OCCONF;
        oc_data_d = head.conf;
      end
      SEQ_LOAD_CONF: state_d = SEQ_WAIT;
      SEQ_WAIT: begin
        if (sel_tm == head.cmp) state_d = SEQ_ADVANCE;
        else if (!en_q)         state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
    if (flush) begin
      state_d   = SEQ_IDLE;
      oc_wr_d   = 1'b0;
      oc_addr_d = oc_addr_q;
      oc_data_d = oc_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEQ_IDLE;
      en_q      <= 1'b0;
      cmp_q     <= '0;
      ovr_q     <= 1'b0;
      rdata_q   <= '0;
      oc_wr_q   <= 1'b0;
      oc_addr_q <= '0;
      oc_data_q <= '0;
`ifdef OC_SEQ_LOOP_EN
      loop_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      cmp_q     <= cmp_d;
      ovr_q     <= ovr_d;
      rdata_q   <= rdata_d;
      oc_wr_q   <= oc_wr_d;
      oc_addr_q <= oc_addr_d;
      oc_data_q <= oc_data_d;
`ifdef OC_SEQ_LOOP_EN
      loop_q    <= loop_d;
`endif
    end
  end

  assign data_o    = rdata_q;
  assign oc_wr_o   = oc_wr_q;
  assign oc_addr_o = oc_addr_q;
  assign oc_data_o = oc_data_q;

endmodule

// File: tb/tb_oc_seq.sv
// tb_oc_seq: self-checking bench for oc_seq. A queue-based reference model
// tracks the entry list, registers and oc write stream; one negedge process
// compares every DUT output against it, and directed scenarios pin the model
// with hand-computed values. Follows OC_SEQ_LOOP_EN the same way as the RTL.
`timescale 1ns/1ps
module tb_oc_seq;

  localparam int unsigned DEPTH = 8;
`ifdef OC_SEQ_LOOP_EN
  localparam bit LOOP_BUILT = 1'b1;
`else
  localparam bit LOOP_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0, tm1 = '0, tm2 = '0;
  logic        wr_i = 1'b0, rd_i = 1'b0;
  logic [31:0] data_o, oc_addr_o, oc_data_o;
  logic        oc_wr_o;

  oc_seq #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .wr_i      (wr_i),
    .rd_i      (rd_i),
    .data_o    (data_o),
    .tm1       (tm1),
    .tm2       (tm2),
    .oc_addr_o (oc_addr_o),
    .oc_data_o (oc_data_o),
    .oc_wr_o   (oc_wr_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_OCR = 1, P_CONF = 2, P_WAIT = 3, P_ADV = 4;
  logic [63:0] mq[$];
  bit          m_en = 0, m_loop = 0, m_ovr = 0, m_owr = 0;
  logic [31:0] m_cmp = '0, m_rdata = '0, m_oaddr = '0, m_odata = '0;
  int          m_phase = P_IDLE;
  int          tick = 0;
  logic [31:0] watch_val = 32'hFFFF_FFFF;
  int          watch_tick = -1;

  function automatic logic [31:0] m_stat();
    logic [31:0] s = '0;
    s[7:0] = 8'(mq.size());
    s[8]   = (mq.size() == 0);
    s[9]   = (mq.size() == DEPTH);
    s[10]  = (m_phase != P_IDLE);
    s[11]  = m_ovr;
    return s;
  endfunction

  task automatic model_step();
    logic [63:0] hd, ent;
    logic [31:0] sel, na, nd;
    bit          flush, repushed, nwr;
    int          nph;
    hd    = (mq.size() != 0) ? mq[0] : 64'h0;
    flush = wr_i && (addr_i == 0) && data_i[2];
    if (rd_i) begin
      case (addr_i)
        0:       m_rdata = {30'b0, m_loop, m_en};
        1:       m_rdata = m_stat();
        2:       m_rdata = m_cmp;
        default: m_rdata = '0;
      endcase
    end
    nph = m_phase; nwr = 0; na = m_oaddr; nd = m_odata;
    case (m_phase)
      P_IDLE: if (m_en && mq.size() != 0) begin nph = P_OCR; nwr = 1; na = 1; nd = hd[63:32]; end
      P_OCR:  begin nph = P_CONF; nwr = 1; na = 0; nd = hd[31:0]; end
      P_CONF: nph = P_WAIT;
      P_WAIT: begin
        sel = hd[3] ? tm2 : tm1;
        if (sel == hd[63:32]) nph = P_ADV;
        else if (!m_en)       nph = P_IDLE;
      end
      default: nph = P_IDLE;
    endcase
    repushed = 0;
    if (flush) begin
      mq.delete();
      m_ovr = 0; m_phase = P_IDLE; m_owr = 0;
    end else begin
      if (m_phase == P_ADV) begin
        ent = mq.pop_front();
        if (m_loop) begin mq.push_back(ent); repushed = 1; end
      end
      if (wr_i && addr_i == 3) begin
        if (!repushed && mq.size() < DEPTH) mq.push_back({m_cmp, data_i});
        else m_ovr = 1;
      end
      if (wr_i && addr_i == 1 && data_i[11]) m_ovr = 0;
      m_phase = nph; m_owr = nwr; m_oaddr = na; m_odata = nd;
    end
    if (wr_i && addr_i == 0) begin
      m_en   = data_i[0];
      m_loop = LOOP_BUILT && data_i[1];
    end
    if (wr_i && addr_i == 2) m_cmp = data_i;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_en = 0; m_loop = 0; m_ovr = 0; m_owr = 0;
      m_cmp = '0; m_rdata = '0; m_oaddr = '0; m_odata = '0;
      m_phase = P_IDLE;
    end else begin
      tick++;
      if (tm1 == watch_val) watch_tick = tick;
      model_step();
    end
  end

  // ---------------- compare process + oc write log ----------------
  typedef struct { int t; logic [31:0] a; logic [31:0] d; } wr_rec_t;
  wr_rec_t wlog[$];

  always @(negedge clk) begin
    check("data_o",    data_o,           m_rdata);
    check("oc_wr_o",   {31'b0, oc_wr_o}, {31'b0, m_owr});
    check("oc_addr_o", oc_addr_o,        m_oaddr);
    check("oc_data_o", oc_data_o,        m_odata);
    if (oc_wr_o) wlog.push_back('{tick, oc_addr_o, oc_data_o});
  end

  // ---------------- stimulus helpers ----------------
  bit tm_ramp1 = 0, tm_ramp2 = 0;
  always @(negedge clk) begin
    if (tm_ramp1) tm1 = tm1 + 1;
    if (tm_ramp2) tm2 = (tm2 == 63) ? 32'd0 : tm2 + 1;
  end

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); addr_i = a; data_i = d; wr_i = 1'b1;
    @(negedge clk); wr_i = 1'b0;
  endtask

  task automatic cpu_rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk); addr_i = a; rd_i = 1'b1;
    @(negedge clk); rd_i = 1'b0; v = data_o;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int n50;

    #1 rst = 1'b1;
    #21 rst = 1'b0;
    cpu_rd(1, v);
    check("reset STAT", v, 32'h100);

    // Two-entry sequence against a ramping tm1
    wlog.delete(); watch_val = 100;
    cpu_wr(2, 100); cpu_wr(3, 32'h1);
    cpu_wr(2, 200); cpu_wr(3, 32'h2);
    tm1 = 0; tm_ramp1 = 1;
    cpu_wr(0, 32'h1);
    repeat (230) @(negedge clk);
    tm_ramp1 = 0;
    check("seq write count", wlog.size(), 4);
    if (wlog.size() >= 4) begin
      check("seq w0 addr", wlog[0].a, 1);  check("seq w0 data", wlog[0].d, 100);
      check("seq w1 addr", wlog[1].a, 0);  check("seq w1 data", wlog[1].d, 1);
      check("seq w1 follows w0", wlog[1].t - wlog[0].t, 1);
      check("seq w2 addr", wlog[2].a, 1);  check("seq w2 data", wlog[2].d, 200);
      // match edge -> ADVANCE, +1 -> IDLE, +2 -> LOAD_OCR (3rd cycle after match cycle)
      check("seq match-to-OCR", wlog[2].t - watch_tick, 2);
      check("seq w3 addr", wlog[3].a, 0);  check("seq w3 data", wlog[3].d, 2);
    end
    cpu_rd(1, v);
    check("seq STAT empty", v, 32'h100);
    cpu_wr(0, 32'h0);
    watch_val = 32'hFFFF_FFFF;

    // Overrun with DEPTH+1 pushes, clear, flush
    for (int unsigned i = 0; i < 9; i++) begin
      cpu_wr(2, 300 + i); cpu_wr(3, i);
    end
    cpu_rd(1, v);
    check("overrun STAT", v, 32'hA08);
    cpu_wr(1, 32'h800);
    cpu_rd(1, v);
    check("overrun cleared STAT", v, 32'h208);
    cpu_wr(0, 32'h4);
    cpu_rd(1, v);
    check("flush STAT", v, 32'h100);

    // LOOP with a single tm2 entry
    wlog.delete(); tm2 = 0;
    cpu_wr(2, 50); cpu_wr(3, 32'h8);
    tm_ramp2 = 1;
    cpu_wr(0, 32'h3);
    repeat (200) @(negedge clk);
    n50 = 0;
    foreach (wlog[i]) if (wlog[i].a == 1 && wlog[i].d == 50) n50++;
    cpu_rd(1, v);
`ifdef OC_SEQ_LOOP_EN
    check("loop reloads >= 3", {31'b0, n50 >= 3}, 1);
    check("loop count stays 1", v & 32'hFF, 1);
`else
    check("no-loop single load", n50, 1);
    check("no-loop count 0", v & 32'hFF, 0);
`endif
    cpu_rd(0, v);
    check("CTRL readback", v, LOOP_BUILT ? 32'h3 : 32'h1);
    tm_ramp2 = 0;
    cpu_wr(0, 32'h4);

    // EN cleared in WAIT keeps the head, re-enable reloads it
    wlog.delete(); tm1 = 0;
    cpu_wr(2, 777); cpu_wr(3, 32'h0);
    cpu_wr(0, 32'h1);
    repeat (5) @(negedge clk);
    cpu_wr(0, 32'h0);
    cpu_rd(1, v);
    check("EN off STAT", v, 32'h001);
    cpu_wr(0, 32'h1);
    repeat (4) @(negedge clk);
    check("EN re-enable writes", wlog.size(), 4);
    if (wlog.size() >= 4) begin
      check("reload OCR addr", wlog[2].a, 1);
      check("reload OCR data", wlog[2].d, 777);
    end
    cpu_wr(0, 32'h4);

    // FLUSH landing on LOAD_OCR: no OCCONF write follows
    wlog.delete();
    cpu_wr(2, 500); cpu_wr(3, 32'h5);
    cpu_wr(0, 32'h1);
    cpu_wr(0, 32'h4);
    cpu_rd(1, v);
    check("flush-in-load writes", wlog.size(), 1);
    check("flush-in-load STAT", v, 32'h100);

    // Asynchronous reset mid-WAIT with 3 entries queued
    tm1 = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      cpu_wr(2, 900 + i); cpu_wr(3, 32'h5);
    end
    cpu_wr(0, 32'h1);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst data_o", data_o, 0);
    check("rst oc_wr_o", {31'b0, oc_wr_o}, 0);
    check("rst oc_addr_o", oc_addr_o, 0);
    check("rst oc_data_o", oc_data_o, 0);
    #2 rst = 1'b0;
    wlog.delete();
    repeat (5) @(negedge clk);
    cpu_rd(1, v);
    check("rst STAT", v, 32'h100);
    check("rst no oc writes", wlog.size(), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      wr_i = 1'b0; rd_i = 1'b0;
      tm1 = $urandom_range(0, 7);
      tm2 = $urandom_range(0, 7);
      r = $urandom_range(0, 99);
      if (r < 30) begin
        addr_i = 3; data_i = $urandom; wr_i = 1'b1;
      end else if (r < 45) begin
        addr_i = 2; data_i = $urandom_range(0, 7); wr_i = 1'b1;
      end else if (r < 53) begin
        addr_i = 0;
        data_i = {29'b0, ($urandom_range(0, 99) < 15), 1'($urandom), ($urandom_range(0, 99) < 85)};
        wr_i = 1'b1;
      end else if (r < 56) begin
        addr_i = 1; data_i = $urandom; wr_i = 1'b1;
      end else if (r < 72) begin
        addr_i = $urandom_range(0, 5); rd_i = 1'b1;
      end
      if (i == 1500) begin
        #3 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    @(negedge clk);
    wr_i = 1'b0; rd_i = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
